shifter_pipe: RTL and testbench



---
 rtl/shifter_pipe.sv | 199 +++++++++++++++++++
 tb/tb_shifter_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter for operand 2: LSL/LSR/ASR/ROR/RRX in immediate or register form, with carry-out.
// Operations are decoded into a single right rotate or shift with a fill bit; the mux levels are spread over STAGES registers.
module shifter_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_W  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  input  logic [NUM_W-1:0] in_num,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag
);

  localparam int          LW  = $clog2(WIDTH);
  localparam logic [31:0] W32 = WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic [LW-1:0]    amt;
    logic             left;
    logic             rot;
    logic             fill;
    logic             allf;
    logic             carry;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t              dec;
  op_t              src      [STAGES];
  op_t              stg_d    [STAGES];
  op_t              stg_q    [STAGES];
  logic             vsrc     [STAGES];
  logic             vld_d    [STAGES];
  logic             vld_q    [STAGES];
  logic             adv;
  logic [31:0]      n_ext;
  logic [LW-1:0]    n_lo;
  logic             msb;
  logic [WIDTH-1:0] out_dat_d;
  logic             out_carry_d;
  logic [TAG_W-1:0] out_tag_d;
  logic [WIDTH-1:0] out_dat_q;
  logic             out_carry_q;
  logic [TAG_W-1:0] out_tag_q;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  // Applies the shift levels owned by pipeline stage stg; level l moves by 2**l.
  function automatic logic [WIDTH-1:0] shift_part(input logic [WIDTH-1:0] d, input logic [LW-1:0] amt,
                                                 input logic rot, input logic fill, input int stg);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] ins;
    r = d;
    for (int l = 0; l < LW; l++) begin
      if (((l * STAGES) / LW == stg) && amt[l]) begin
        ins = rot ? (r << (WIDTH - (1 << l))) : ({WIDTH{fill}} << (WIDTH - (1 << l)));
        r   = (r >> (1 << l)) | ins;
      end
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] finalize(input op_t o);
    logic [WIDTH-1:0] r;
    r = o.allf ? {WIDTH{o.fill}} : o.dat;
    return o.left ? bitrev(r) : r;
  endfunction

  // Decode: left shifts become right shifts of the bit-reversed operand, carry is picked here.
  always_comb begin
    n_ext     = 32'(in_num);
    n_lo      = n_ext[LW-1:0];
    msb       = in_data[WIDTH-1];
    dec       = '0;
    dec.dat   = in_data;
    dec.carry = in_carry;
    dec.tag   = in_tag;
    if (n_ext == 32'd0) begin
      if (!in_op[0]) begin
        case (in_op[2:1])
          2'b01: begin
            dec.allf  = 1'b1;
            dec.carry = msb;
          end
          2'b10: begin
            dec.allf  = 1'b1;
            dec.fill  = msb;
            dec.carry = msb;
          end
          2'b11: begin
            dec.amt   = LW'(1);
            dec.fill  = in_carry;
            dec.carry = in_data[0];
          end
          default: ;
        endcase
      end
    end else begin
      case (in_op[2:1])
        2'b00: begin
          if (n_ext < W32) begin
            dec.left  = 1'b1;
            dec.dat   = bitrev(in_data);
            dec.amt   = n_lo;
            dec.carry = in_data[LW'(0) - n_lo];
          end else begin
            dec.allf  = 1'b1;
            dec.carry = (n_ext == W32) ? in_data[0] : 1'b0;
          end
        end
        2'b01: begin
          if (n_ext < W32) begin
            dec.amt   = n_lo;
            dec.carry = in_data[n_lo - LW'(1)];
          end else begin
            dec.allf  = 1'b1;
            dec.carry = (n_ext == W32) ? msb : 1'b0;
          end
        end
        2'b10: begin
          dec.fill = msb;
          if (n_ext < W32) begin
            dec.amt   = n_lo;
            dec.carry = in_data[n_lo - LW'(1)];
          end else begin
            dec.allf  = 1'b1;
            dec.carry = msb;
          end
        end
        default: begin
          dec.rot   = 1'b1;
          dec.amt   = n_lo;
          dec.carry = (n_lo == '0) ? msb : in_data[n_lo - LW'(1)];
        end
      endcase
    end
  end

  // Stage boundaries: every stage advances together on adv, bubbles included.
  always_comb begin
    adv     = !vld_q[STAGES-1] || out_ready;
    src[0]  = dec;
    vsrc[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      src[s]  = stg_q[s-1];
      vsrc[s] = vld_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      stg_d[s]     = src[s];
      stg_d[s].dat = shift_part(src[s].dat, src[s].amt, src[s].rot, src[s].fill, s);
      vld_d[s]     = vsrc[s];
    end
    out_dat_d   = finalize(stg_d[STAGES-1]);
    out_carry_d = stg_d[STAGES-1].carry;
    out_tag_d   = stg_d[STAGES-1].tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) vld_q[s] <= 1'b0;
      out_dat_q   <= '0;
      out_carry_q <= 1'b0;
      out_tag_q   <= '0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) vld_q[s] <= vld_d[s];
      out_dat_q   <= out_dat_d;
      out_carry_q <= out_carry_d;
      out_tag_q   <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int s = 0; s < STAGES - 1; s++) stg_q[s] <= stg_d[s];
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = out_dat_q;
  assign out_carry = out_carry_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: literal test-plan cases, a stalled stream, random traffic and mid-flight reset,
// all scored against a rule-level reference model.
module tb_shifter_pipe;
  localparam int WIDTH  = 32;
  localparam int NUM_W  = 8;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_carry;
  logic [NUM_W-1:0] in_num;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic [TAG_W-1:0] out_tag;

  shifter_pipe #(.WIDTH(WIDTH), .NUM_W(NUM_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_carry(in_carry), .in_num(in_num), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        c;
    logic [3:0]  t;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         out_count = 0;
  logic [3:0] tag_ctr = 4'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic bit_at(input logic [31:0] d, input int i);
    logic [31:0] t;
    t = d >> i;
    return t[0];
  endfunction

  // Reference: {result, carry} straight from the shift rules.
  function automatic logic [32:0] ref_shift(input logic [31:0] d, input logic c, input int n, input logic [2:0] op);
    logic signed [31:0] sd;
    logic [31:0]        res;
    int                 r;
    sd = d;
    if (n == 0) begin
      if (op[0]) return {d, c};
      case (op[2:1])
        2'd0:    return {d, c};
        2'd1:    return {32'h0, d[31]};
        2'd2:    return {{32{d[31]}}, d[31]};
        default: return {c, d[31:1], d[0]};
      endcase
    end
    case (op[2:1])
      2'd0: begin
        if (n < 32) return {d << n, bit_at(d, 32 - n)};
        if (n == 32) return {32'h0, d[0]};
        return 33'h0;
      end
      2'd1: begin
        if (n < 32) return {d >> n, bit_at(d, n - 1)};
        if (n == 32) return {32'h0, d[31]};
        return 33'h0;
      end
      2'd2: begin
        if (n < 32) begin
          res = sd >>> n;
          return {res, bit_at(d, n - 1)};
        end
        return {{32{d[31]}}, d[31]};
      end
      default: begin
        r = n % 32;
        if (r == 0) return {d, d[31]};
        return {(d >> r) | (d << (32 - r)), bit_at(d, r - 1)};
      end
    endcase
  endfunction

  // Scoreboard and handshake checks, sampled on the falling edge.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_c;
  logic [3:0]  prev_t;
  always @(negedge clk) begin
    exp_t        e;
    logic [32:0] m;
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_d);
        chk("hold_carry", out_carry, prev_c);
        chk("hold_tag", out_tag, prev_t);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data %h tag %h, expected no result", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_carry", out_carry, e.c);
          chk("sb_tag", out_tag, e.t);
          out_count++;
        end
      end
      if (in_valid && in_ready) begin
        m   = ref_shift(in_data, in_carry, int'(in_num), in_op);
        e.d = m[32:1];
        e.c = m[0];
        e.t = in_tag;
        sb.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_c     = out_carry;
      prev_t     = out_tag;
    end
  end

  task automatic drive_op(input logic [31:0] d, input logic c, input logic [7:0] n, input logic [2:0] op);
    in_valid = 1'b1;
    in_data  = d;
    in_carry = c;
    in_num   = n;
    in_op    = op;
    in_tag   = tag_ctr;
    tag_ctr  = tag_ctr + 4'd1;
  endtask

  function automatic logic [7:0] pick_num();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd1;
      2:       return 8'd31;
      3:       return 8'd32;
      4:       return 8'($urandom_range(33, 64));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic drive_rand();
    drive_op($urandom, 1'($urandom_range(0, 1)), pick_num(), 3'($urandom_range(0, 7)));
  endtask

  // Called just after a rising edge with an idle pipeline and out_ready high.
  task automatic lit(input string name, input logic [31:0] d, input logic c, input logic [7:0] n,
                     input logic [2:0] op, input logic [31:0] ed, input logic ec);
    logic [3:0] t;
    t = tag_ctr;
    drive_op(d, c, n, op);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_carry = ~c;
    chk({name, "_early"}, out_valid, 0);
    repeat (STAGES - 1) @(posedge clk);
    #1;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, ed);
    chk({name, "_carry"}, out_carry, ec);
    chk({name, "_tag"}, out_tag, t);
  endtask

  task automatic wait_accept();
    logic acc;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance in %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    int   base;
    logic acc;
    in_valid = 1'b0; in_data = '0; in_carry = 1'b0; in_num = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    lit("lsl_reg_1",    32'h8000_0001, 1'b0, 8'd1,  3'b001, 32'h0000_0002, 1'b1);
    lit("lsr_imm_0",    32'h8000_0000, 1'b0, 8'd0,  3'b010, 32'h0000_0000, 1'b1);
    lit("asr_imm_0",    32'h8000_0000, 1'b0, 8'd0,  3'b100, 32'hFFFF_FFFF, 1'b1);
    lit("rrx",          32'h0000_0003, 1'b1, 8'd0,  3'b110, 32'h8000_0001, 1'b1);
    lit("ror_reg_36",   32'h0000_00F1, 1'b0, 8'd36, 3'b111, 32'h1000_000F, 1'b0);
    lit("lsl_reg_32",   32'h0000_0001, 1'b0, 8'd32, 3'b001, 32'h0000_0000, 1'b1);
    lit("lsl_reg_33",   32'h0000_0001, 1'b0, 8'd33, 3'b001, 32'h0000_0000, 1'b0);
    lit("reg_n0_pass",  32'h1234_5678, 1'b1, 8'd0,  3'b011, 32'h1234_5678, 1'b1);
    lit("asr_reg_4",    32'h8000_00F0, 1'b1, 8'd4,  3'b101, 32'hF800_000F, 1'b0);
    lit("lsr_reg_31",   32'h8000_0000, 1'b1, 8'd31, 3'b011, 32'h0000_0001, 1'b0);
    lit("asr_reg_40",   32'h7FFF_FFFF, 1'b1, 8'd40, 3'b101, 32'h0000_0000, 1'b0);
    lit("lsr_reg_32",   32'h8000_0000, 1'b0, 8'd32, 3'b011, 32'h0000_0000, 1'b1);
    lit("ror_reg_32",   32'h8000_0001, 1'b0, 8'd32, 3'b111, 32'h8000_0001, 1'b1);
    lit("lsl_imm_0",    32'h0000_00A5, 1'b0, 8'd0,  3'b000, 32'h0000_00A5, 1'b0);
    drain();

    base = out_count;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive_rand();
          wait_accept();
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", out_count - base, 8);

    base = out_count;
    acc = 1'b1;
    for (int cy = 0; cy < 1500; cy++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0) drive_rand();
        else begin
          in_valid = 1'b0;
          in_carry = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_progress", (out_count - base) > 500, 1);

    drive_rand();
    @(posedge clk); #1;
    drive_rand();
    @(posedge clk); #2;
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_data", out_data, 0);
    chk("rst_async_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    lit("post_rst", 32'h0000_0F00, 1'b0, 8'd8, 3'b011, 32'h0000_000F, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
